// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding,
// default timing limits and a constant-width helper.
package bus_arbiter_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ENC_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ENC_GRANT      = 3'd1;
    localparam logic [STATE_W-1:0] ENC_WAIT_BEGIN = 3'd2;
    localparam logic [STATE_W-1:0] ENC_BUSY       = 3'd3;
    localparam logic [STATE_W-1:0] ENC_ABORT      = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = ENC_IDLE,
        ST_GRANT      = ENC_GRANT,
        ST_WAIT_BEGIN = ENC_WAIT_BEGIN,
        ST_BUSY       = ENC_BUSY,
        ST_ABORT      = ENC_ABORT
    } arb_state_t;

    localparam int DEFAULT_GRANT_WAIT     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    function automatic int clog2(input int value);
        int r = 0;
        int v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Masked priority picker: first set request at index >= rr_pointer,
// falling back to the lowest set request when nothing is set above it.
module rr_select
    import bus_arbiter_pkg::*;
#(
    parameter  int NR_MASTERS = 4,
    localparam int MW         = clog2(NR_MASTERS)
) (
    input  logic [NR_MASTERS-1:0] request,
    input  logic [MW-1:0]         rr_pointer,
    output logic [MW-1:0]         winner,
    output logic                  valid
);

    logic [NR_MASTERS-1:0] upper_mask;
    logic [NR_MASTERS-1:0] masked;
    logic [NR_MASTERS-1:0] pick_vec;

    for (genvar i = 0; i < NR_MASTERS; i++) begin : g_mask
        assign upper_mask[i] = (MW'(i) >= rr_pointer);
    end

    assign masked   = request & upper_mask;
    assign pick_vec = (|masked) ? masked : request;
    assign valid    = |request;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        winner = '0;
        for (int i = NR_MASTERS - 1; i >= 0; i--) begin
            if (pick_vec[i]) winner = MW'(i);
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with grant-to-begin timeout and BUSY watchdog that
// aborts hung transactions with an end + error strobe.
module bus_arbiter_rr
    import bus_arbiter_pkg::*;
#(
    parameter  int NR_MASTERS     = 4,
    parameter  int GRANT_WAIT     = DEFAULT_GRANT_WAIT,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int MW             = clog2(NR_MASTERS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NR_MASTERS-1:0] request,
    output logic [NR_MASTERS-1:0] granted,
    input  logic                  begin_transaction_in,
    input  logic                  end_transaction_in,
    input  logic                  data_valid_in,
    input  logic                  error_in,
    output logic                  end_transaction_out,
    output logic                  bus_error_out,
    output logic [MW-1:0]         active_master,
    output logic                  bus_idle
);

    localparam int WW = clog2(GRANT_WAIT + 1);
    localparam int TW = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(GRANT_WAIT);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [MW-1:0] LAST     = MW'(NR_MASTERS - 1);

    arb_state_t    state, state_next;
    logic [MW-1:0] rr_pointer;
    logic [MW-1:0] pick_idx;
    logic          pick_valid;
    logic [WW-1:0] wait_cnt, wait_inc;
    logic [TW-1:0] wd_cnt, wd_inc;

    rr_select #(.NR_MASTERS(NR_MASTERS)) u_rr_select (
        .request    (request),
        .rr_pointer (rr_pointer),
        .winner     (pick_idx),
        .valid      (pick_valid)
    );

    assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);
    assign wd_inc   = (wd_cnt == TO_MAX) ? wd_cnt : wd_cnt + TW'(1);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (pick_valid) state_next = ST_GRANT;
            ST_GRANT:      state_next = ST_WAIT_BEGIN;
            ST_WAIT_BEGIN: begin
                // A lone end strobe here belongs to nobody; only begin counts.
                if (begin_transaction_in)
                    state_next = end_transaction_in ? ST_IDLE : ST_BUSY;
                else if (wait_inc == WAIT_MAX)
                    state_next = ST_IDLE;
            end
            ST_BUSY: begin
                if (end_transaction_in || error_in)
                    state_next = ST_IDLE;
                else if (!data_valid_in && wd_inc == TO_MAX)
                    state_next = ST_ABORT;
            end
            ST_ABORT:      state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            active_master <= '0;
            rr_pointer    <= '0;
            wait_cnt      <= '0;
            wd_cnt        <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE:       if (pick_valid) active_master <= pick_idx;
                ST_GRANT: begin
                    rr_pointer <= (active_master == LAST) ? '0 : active_master + MW'(1);
                    wait_cnt   <= '0;
                end
                ST_WAIT_BEGIN: begin
                    wait_cnt <= wait_inc;
                    wd_cnt   <= '0;
                end
                ST_BUSY:       wd_cnt <= data_valid_in ? '0 : wd_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        granted = '0;
        if (state == ST_GRANT) granted[active_master] = 1'b1;
    end

    assign end_transaction_out = (state == ST_ABORT);
    assign bus_error_out       = (state == ST_ABORT);
    assign bus_idle            = (state == ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: grant timing, round-robin order,
// grant-wait timeout, watchdog abort, slave error and mid-transaction reset.
module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int GW = 4;
    localparam int TO = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] request = '0;
    logic [N-1:0] granted;
    logic         begin_transaction_in = 1'b0;
    logic         end_transaction_in   = 1'b0;
    logic         data_valid_in        = 1'b0;
    logic         error_in             = 1'b0;
    logic         end_transaction_out;
    logic         bus_error_out;
    logic [1:0]   active_master;
    logic         bus_idle;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bus_arbiter_rr #(
        .NR_MASTERS     (N),
        .GRANT_WAIT     (GW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .request              (request),
        .granted              (granted),
        .begin_transaction_in (begin_transaction_in),
        .end_transaction_in   (end_transaction_in),
        .data_valid_in        (data_valid_in),
        .error_in             (error_in),
        .end_transaction_out  (end_transaction_out),
        .bus_error_out        (bus_error_out),
        .active_master        (active_master),
        .bus_idle             (bus_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each call lands 1 time unit into the next cycle: outputs seen here and
    // inputs driven here both belong to that cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] strobes();
        return {end_transaction_out, bus_error_out};
    endfunction

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_granted", granted, 0);
        chk("rst_strobes", strobes(), 0);
        chk("rst_active", active_master, 0);
        chk("rst_idle", bus_idle, 1);
        reset = 1'b0;

        // single requester: request c0, grant c1, begin c2, end c10, idle c11
        request = 4'b0100;
        chk("t1_idle_c0", bus_idle, 1);
        tick();
        chk("t1_grant_c1", granted, 4'b0100);
        chk("t1_active_c1", active_master, 2);
        request = '0;
        tick();
        chk("t1_nogrant_c2", granted, 0);
        begin_transaction_in = 1'b1;
        tick();
        begin_transaction_in = 1'b0;
        chk("t1_busy_c3", bus_idle, 0);
        for (int c = 4; c <= 10; c++) begin
            tick();
            chk("t1_active", active_master, 2);
            chk("t1_nogrant", granted, 0);
            if (c == 10) end_transaction_in = 1'b1;
        end
        tick();
        end_transaction_in = 1'b0;
        chk("t1_idle_c11", bus_idle, 1);
        chk("t1_active_c11", active_master, 2);

        // fairness from pointer 0: grant order 0,1,2,3,0,1, grant at end+2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        request = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            chk("t2_idle", bus_idle, 1);
            chk("t2_gap_nogrant", granted, 0);
            tick();
            chk("t2_grant", granted, 32'(1) << (k % 4));
            chk("t2_active", active_master, k % 4);
            tick();
            begin_transaction_in = 1'b1;
            tick();
            begin_transaction_in = 1'b0;
            data_valid_in = 1'b1;
            tick();
            tick();
            end_transaction_in = 1'b1;
            tick();
            data_valid_in = 1'b0;
            end_transaction_in = 1'b0;
        end
        request = '0;

        // grant to 1 (wraps from pointer 2), no begin -> silent return after GW waits
        request = 4'b0010;
        tick();
        chk("t3_grant_c1", granted, 4'b0010);
        request = '0;
        tick();
        chk("t3_wait_c2", bus_idle, 0);
        tick();
        end_transaction_in = 1'b1;
        tick();
        end_transaction_in = 1'b0;
        chk("t3_end_ignored_c4", bus_idle, 0);
        tick();
        chk("t3_wait_c5", bus_idle, 0);
        tick();
        chk("t3_idle_c6", bus_idle, 1);
        chk("t3_nostrobe_c6", strobes(), 0);
        request = 4'b0110;
        tick();
        chk("t3_next_grant", granted, 4'b0100);
        request = '0;
        tick();
        begin_transaction_in = 1'b1;
        end_transaction_in   = 1'b1;
        tick();
        begin_transaction_in = 1'b0;
        end_transaction_in   = 1'b0;
        chk("t3_single_beat_idle", bus_idle, 1);

        // watchdog: begin c5, no data -> strobe only at c22
        request = 4'b1000;
        tick();
        chk("t4a_grant", granted, 4'b1000);
        request = '0;
        repeat (4) tick();
        begin_transaction_in = 1'b1;
        for (int c = 6; c <= 23; c++) begin
            tick();
            begin_transaction_in = 1'b0;
            chk("t4a_strobe", strobes(), (c == 22) ? 2'b11 : 2'b00);
            if (c == 21) chk("t4a_busy_c21", bus_idle, 0);
        end
        chk("t4a_idle_c23", bus_idle, 1);

        // watchdog with data_valid at c15 -> strobe moves to c32
        request = 4'b0001;
        tick();
        chk("t4b_grant", granted, 4'b0001);
        request = '0;
        repeat (4) tick();
        begin_transaction_in = 1'b1;
        for (int c = 6; c <= 33; c++) begin
            tick();
            begin_transaction_in = 1'b0;
            data_valid_in = (c == 15);
            chk("t4b_strobe", strobes(), (c == 32) ? 2'b11 : 2'b00);
        end
        chk("t4b_idle_c33", bus_idle, 1);

        // slave error alone, then error with end
        request = 4'b0010;
        tick();
        chk("t5_grant_a", granted, 4'b0010);
        tick();
        begin_transaction_in = 1'b1;
        tick();
        begin_transaction_in = 1'b0;
        tick();
        error_in = 1'b1;
        chk("t5_nostrobe_c4", strobes(), 0);
        tick();
        error_in = 1'b0;
        chk("t5_idle_c5", bus_idle, 1);
        chk("t5_nostrobe_c5", strobes(), 0);
        tick();
        chk("t5_grant_b", granted, 4'b0010);
        request = '0;
        tick();
        begin_transaction_in = 1'b1;
        tick();
        begin_transaction_in = 1'b0;
        error_in = 1'b1;
        end_transaction_in = 1'b1;
        tick();
        error_in = 1'b0;
        end_transaction_in = 1'b0;
        chk("t5_idle_c9", bus_idle, 1);
        chk("t5_nostrobe_c9", strobes(), 0);

        // reset while BUSY; pointer would be 1, reset must bring it to 0
        request = 4'b0001;
        tick();
        chk("t6_grant0", granted, 4'b0001);
        tick();
        begin_transaction_in = 1'b1;
        request = 4'b0111;
        tick();
        begin_transaction_in = 1'b0;
        chk("t6_busy_c3", bus_idle, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_granted", granted, 0);
        chk("t6_rst_strobes", strobes(), 0);
        chk("t6_rst_active", active_master, 0);
        chk("t6_rst_idle", bus_idle, 1);
        tick();
        chk("t6_ptr_reset_grant", granted, 4'b0001);
        request = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
